// File: rtl/spi_flash_pkg.sv
// Shared constants, state type and command helper for the SPI flash responder.
package spi_flash_pkg;

   localparam logic [7:0] CMD_READ  = 8'h01;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] MISO_IDLE = 8'hFF;

   localparam logic [3:0] BYTE_CMD       = 4'd1;
   localparam logic [3:0] BYTE_ADDR_LAST = 4'd4;
   localparam logic [3:0] BYTE_DATA_LAST = 4'd8;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      DRAIN
   } state_e;

   function automatic logic cmd_known(input logic [7:0] c);
      return (c == CMD_READ) || (c == CMD_WRITE);
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes s_clk/s_css into p_clk and produces one-cycle edge pulses.
// s_mosi is delayed by the same number of stages so mosi_q is valid with clk_rise.
module spi_edge_sync #(
   parameter int W = 8
) (
   input  logic         p_clk,
   input  logic         p_reset,
   input  logic         s_clk,
   input  logic         s_css,
   input  logic [W-1:0] s_mosi,
   output logic         clk_rise,
   output logic         css_fall,
   output logic         css_rise,
   output logic [W-1:0] mosi_q
);

   logic [1:0]   clk_sync_q;
   logic [1:0]   css_sync_q;
   logic         clk_prev_q;
   logic         css_prev_q;
   logic         clk_rise_q;
   logic         css_fall_q;
   logic         css_rise_q;
   logic [W-1:0] mosi_s0_q;
   logic [W-1:0] mosi_s1_q;
   logic [W-1:0] mosi_s2_q;

   // Two-flop synchronizers, a history flop and registered edge pulses (pin edge + 3 p_clk).
   // css resets high so a released reset with css already high raises no edge.
   always_ff @(posedge p_clk or posedge p_reset) begin
      if (p_reset) begin
         clk_sync_q <= 2'b00;
         css_sync_q <= 2'b11;
         clk_prev_q <= 1'b0;
         css_prev_q <= 1'b1;
         clk_rise_q <= 1'b0;
         css_fall_q <= 1'b0;
         css_rise_q <= 1'b0;
         mosi_s0_q  <= '0;
         mosi_s1_q  <= '0;
         mosi_s2_q  <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], s_clk};
         css_sync_q <= {css_sync_q[0], s_css};
         clk_prev_q <= clk_sync_q[1];
         css_prev_q <= css_sync_q[1];
         clk_rise_q <= clk_sync_q[1] & ~clk_prev_q;
         css_fall_q <= ~css_sync_q[1] & css_prev_q;
         css_rise_q <= css_sync_q[1] & ~css_prev_q;
         mosi_s0_q  <= s_mosi;
         mosi_s1_q  <= mosi_s0_q;
         mosi_s2_q  <= mosi_s1_q;
      end
   end

   assign clk_rise = clk_rise_q;
   assign css_fall = css_fall_q;
   assign css_rise = css_rise_q;
   assign mosi_q   = mosi_s2_q;

endmodule

// File: rtl/spi_flash_responder.sv
// NOR-flash responder: decodes cmd/addr/data frames, stores words, returns read bytes.
//
//   state | meaning
//   IDLE  | css high, waiting for a frame
//   CMD   | frame open, expecting command byte
//   ADDR  | collecting address bytes 2..4
//   DATA  | bytes 5..8: staging write data or shifting read data out
//   DRAIN | frame finished or bad command; bytes ignored until css rises
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int SPIBITWIDE = 8,
   parameter int MEM_WORDS  = 16
) (
   input  logic                  p_clk,
   input  logic                  p_reset,
   input  logic                  s_clk,
   input  logic                  s_css,
   input  logic [SPIBITWIDE-1:0] s_mosi,
   output logic [SPIBITWIDE-1:0] s_miso,
   output logic                  wr_commit,
   output logic                  frame_err
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic                  clk_rise;
   logic                  css_fall;
   logic                  css_rise;
   logic [SPIBITWIDE-1:0] mosi_q;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [7:0]            cmd_q, cmd_d;
   logic [23:0]           addr_q, addr_d;
   logic [23:0]           stage_q, stage_d;
   logic [SPIBITWIDE-1:0] miso_q, miso_d;
   logic                  commit_q, commit_d;
   logic                  err_q, err_d;
   logic                  mem_we;
   logic [31:0]           mem_q [MEM_WORDS];

   logic [3:0]            byte_n;
   logic [23:0]           lk_addr;
   logic                  in_range;
   logic [31:0]           rd_word;

   spi_edge_sync #(.W(SPIBITWIDE)) u_sync (
      .p_clk    (p_clk),
      .p_reset  (p_reset),
      .s_clk    (s_clk),
      .s_css    (s_css),
      .s_mosi   (s_mosi),
      .clk_rise (clk_rise),
      .css_fall (css_fall),
      .css_rise (css_rise),
      .mosi_q   (mosi_q)
   );

   // Number of the byte arriving now; saturates so trailing bytes never alias to the cmd slot.
   assign byte_n   = (cnt_q == BYTE_DATA_LAST) ? cnt_q : cnt_q + 4'd1;
   // On byte 4 the address is not yet registered, so look up with the incoming byte merged in.
   assign lk_addr  = (byte_n == BYTE_ADDR_LAST) ? {addr_q[15:0], mosi_q} : addr_q;
   assign in_range = (lk_addr < 24'(MEM_WORDS));
   assign rd_word  = in_range ? mem_q[lk_addr[AW-1:0]] : 32'hFFFF_FFFF;

   // Frame state register and datapath registers.
   always_ff @(posedge p_clk or posedge p_reset) begin
      if (p_reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cmd_q    <= '0;
         addr_q   <= '0;
         stage_q  <= '0;
         miso_q   <= MISO_IDLE;
         commit_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         stage_q  <= stage_d;
         miso_q   <= miso_d;
         commit_q <= commit_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic; css rise takes priority so a coincident byte is dropped.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      stage_d  = stage_q;
      miso_d   = miso_q;
      commit_d = 1'b0;
      err_d    = err_q;
      mem_we   = 1'b0;
      if (css_rise) begin
         state_d = IDLE;
         cnt_d   = '0;
         miso_d  = MISO_IDLE;
         if ((state_q != IDLE) && (cnt_q >= BYTE_CMD) && (cnt_q < BYTE_DATA_LAST))
            err_d = 1'b1;
      end else if (css_fall) begin
         state_d = CMD;
         cnt_d   = '0;
         err_d   = 1'b0;
         miso_d  = MISO_IDLE;
      end else if (clk_rise && (state_q != IDLE)) begin
         cnt_d = byte_n;
         case (state_q)
            CMD: begin
               cmd_d = mosi_q;
               if (cmd_known(mosi_q)) begin
                  state_d = ADDR;
               end else begin
                  state_d = DRAIN;
                  err_d   = 1'b1;
               end
            end
            ADDR: begin
               addr_d = {addr_q[15:0], mosi_q};
               if (byte_n == BYTE_ADDR_LAST) begin
                  state_d = DATA;
                  if (cmd_q == CMD_READ) miso_d = rd_word[31:24];
               end
            end
            DATA: begin
               if (byte_n == BYTE_DATA_LAST) begin
                  state_d = DRAIN;
                  miso_d  = MISO_IDLE;
                  if ((cmd_q == CMD_WRITE) && in_range) begin
                     mem_we   = 1'b1;
                     commit_d = 1'b1;
                  end
               end else begin
                  stage_d = {stage_q[15:0], mosi_q};
                  if (cmd_q == CMD_READ) begin
                     case (byte_n)
                        4'd5:    miso_d = rd_word[23:16];
                        4'd6:    miso_d = rd_word[15:8];
                        default: miso_d = rd_word[7:0];
                     endcase
                  end
               end
            end
            DRAIN:   miso_d  = MISO_IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Word array; cleared by reset, written on the last data byte of an in-range write.
   always_ff @(posedge p_clk or posedge p_reset) begin
      if (p_reset) begin
         for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q[AW-1:0]] <= {stage_q, mosi_q};
      end
   end

   assign s_miso    = miso_q;
   assign wr_commit = commit_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: frame-level reference model plus a per-cycle compare process.
module tb_spi_flash_responder;

   localparam int MW = 16;

   logic       p_clk = 1'b0;
   logic       p_reset;
   logic       s_clk;
   logic       s_css;
   logic [7:0] s_mosi;
   logic [7:0] s_miso;
   logic       wr_commit;
   logic       frame_err;

   always #5 p_clk = ~p_clk;

   spi_flash_responder #(.SPIBITWIDE(8), .MEM_WORDS(MW)) dut (
      .p_clk     (p_clk),
      .p_reset   (p_reset),
      .s_clk     (s_clk),
      .s_css     (s_css),
      .s_mosi    (s_mosi),
      .s_miso    (s_miso),
      .wr_commit (wr_commit),
      .frame_err (frame_err)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          commit_cnt = 0;
   bit          prev_commit = 0;
   bit          win = 0;

   logic [31:0] mdl_mem [MW];
   logic [7:0]  exp_miso;
   logic        exp_err;
   int          exp_commits;
   logic [7:0]  f_cmd;
   logic [23:0] f_addr;
   logic [31:0] f_data;
   logic [7:0]  fb  [0:11];
   logic [7:0]  got [1:12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge p_clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < MW; i++) mdl_mem[i] = '0;
      exp_miso = 8'hFF;
      exp_err  = 1'b0;
   endtask

   // Effect of the k-th delivered byte of the current frame.
   task automatic model_byte(input int k, input logic [7:0] b);
      logic [31:0] word;
      if (k == 1) begin
         f_cmd = b;
         if (b != 8'h01 && b != 8'h02) exp_err = 1'b1;
      end else if (k <= 4) begin
         f_addr = {f_addr[15:0], b};
      end else if (k <= 8) begin
         f_data = {f_data[23:0], b};
      end
      exp_miso = 8'hFF;
      if (f_cmd == 8'h01 && k >= 4 && k <= 7) begin
         word = (f_addr < MW) ? mdl_mem[f_addr] : 32'hFFFF_FFFF;
         exp_miso = 8'(word >> (8 * (7 - k)));
      end
      if (f_cmd == 8'h02 && k == 8 && f_addr < MW) begin
         mdl_mem[f_addr] = f_data;
         exp_commits++;
      end
   endtask

   task automatic send_byte(input int k);
      s_mosi = fb[k-1];
      cyc(4);
      win   = 0;
      s_clk = 1'b1;
      cyc(6);
      model_byte(k, fb[k-1]);
      got[k] = s_miso;
      win   = 1;
      s_clk = 1'b0;
      cyc(6);
   endtask

   // Delivers n bytes; drop_last adds one more rise coincident with css rise.
   task automatic run_frame(input int n, input bit drop_last);
      int base;
      base        = commit_cnt;
      exp_commits = 0;
      win   = 0;
      s_css = 1'b0;
      cyc(6);
      exp_err  = 1'b0;
      exp_miso = 8'hFF;
      f_cmd  = '0;
      f_addr = '0;
      f_data = '0;
      win = 1;
      for (int k = 1; k <= n; k++) send_byte(k);
      win = 0;
      if (drop_last) begin
         s_mosi = fb[n];
         cyc(4);
         s_clk = 1'b1;
         s_css = 1'b1;
         cyc(6);
         s_clk = 1'b0;
      end else begin
         s_css = 1'b1;
      end
      cyc(6);
      exp_miso = 8'hFF;
      if (n >= 1 && n < 8) exp_err = 1'b1;
      win = 1;
      cyc(4);
      chk("commit_count", commit_cnt - base, exp_commits);
   endtask

   task automatic set_fb(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
      fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
      fb[4] = b4; fb[5] = b5; fb[6] = b6; fb[7] = b7;
      fb[8] = 8'h5A; fb[9] = 8'hA5; fb[10] = 8'h3C; fb[11] = 8'hC3;
   endtask

   // Per-cycle comparison of outputs against the model while they are settled.
   always @(negedge p_clk) begin
      if (!p_reset) begin
         if (prev_commit) chk("wr_commit_width", {31'd0, wr_commit}, 32'd0);
         if (wr_commit) commit_cnt++;
         prev_commit = wr_commit;
         if (win) begin
            chk("s_miso", {24'd0, s_miso}, {24'd0, exp_miso});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
         end
      end else begin
         prev_commit = 0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int base;
      logic [31:0] ra;
      p_reset = 1'b1;
      s_clk   = 1'b0;
      s_css   = 1'b1;
      s_mosi  = 8'h00;
      model_clear();
      cyc(3);
      chk("reset_miso", {24'd0, s_miso}, 32'hFF);
      chk("reset_commit", {31'd0, wr_commit}, 32'd0);
      chk("reset_err", {31'd0, frame_err}, 32'd0);
      p_reset = 1'b0;
      cyc(4);
      win = 1;

      // Write FF00FF00 to word 0, then read it back.
      base = commit_cnt;
      set_fb(8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
      run_frame(8, 0);
      chk("w0_commit_lit", commit_cnt - base, 32'd1);
      set_fb(8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
      run_frame(8, 0);
      chk("r0_b4_lit", {24'd0, got[4]}, 32'hFF);
      chk("r0_b5_lit", {24'd0, got[5]}, 32'h00);
      chk("r0_b6_lit", {24'd0, got[6]}, 32'hFF);
      chk("r0_b7_lit", {24'd0, got[7]}, 32'h00);

      // Out-of-range address: write discarded, read returns FF.
      base = commit_cnt;
      set_fb(8'h02, 8'h00, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78);
      run_frame(8, 0);
      chk("oor_commit_lit", commit_cnt - base, 32'd0);
      set_fb(8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(8, 0);
      chk("oor_b4_lit", {24'd0, got[4]}, 32'hFF);
      chk("oor_b7_lit", {24'd0, got[7]}, 32'hFF);

      // Aborted write after byte 6.
      base = commit_cnt;
      set_fb(8'h02, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
      run_frame(6, 0);
      chk("abort_commit_lit", commit_cnt - base, 32'd0);
      chk("abort_err_lit", {31'd0, frame_err}, 32'd1);
      set_fb(8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(8, 0);
      chk("abort_mem_lit", {got[4], got[5], got[6], got[7]}, 32'h0);
      chk("abort_err_cleared_lit", {31'd0, frame_err}, 32'd0);

      // Unknown command.
      set_fb(8'h9F, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04);
      run_frame(8, 0);
      chk("badcmd_err_lit", {31'd0, frame_err}, 32'd1);

      // css rise coincident with the 8th byte: byte dropped, frame aborted.
      base = commit_cnt;
      set_fb(8'h02, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
      run_frame(7, 1);
      chk("drop_commit_lit", commit_cnt - base, 32'd0);
      chk("drop_err_lit", {31'd0, frame_err}, 32'd1);

      // Long frames: bytes past 8 are ignored.
      set_fb(8'h02, 8'h00, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
      fb[8] = 8'h01;
      fb[9] = 8'h02;
      run_frame(10, 0);
      set_fb(8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
      fb[8] = 8'h01;
      run_frame(10, 0);
      chk("long_rd_lit", {got[4], got[5], got[6], got[7]}, 32'hDEADBEEF);
      chk("long_err_lit", {31'd0, frame_err}, 32'd0);

      // Randomized frames against the model.
      for (int f = 0; f < 40; f++) begin
         int sel;
         int n;
         sel = $urandom_range(0, 9);
         ra  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 19));
         set_fb((sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom),
                ra[23:16], ra[15:8], ra[7:0],
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 10);
         run_frame(n, 0);
      end

      // Reset during byte 3 of a write; array cleared.
      win = 0;
      set_fb(8'h02, 8'h00, 8'h00, 8'h00, 8'h99, 8'h88, 8'h77, 8'h66);
      s_css = 1'b0;
      cyc(6);
      f_cmd = '0;
      f_addr = '0;
      exp_err = 1'b0;
      exp_miso = 8'hFF;
      send_byte(1);
      send_byte(2);
      win = 0;
      s_mosi = fb[2];
      cyc(4);
      s_clk = 1'b1;
      cyc(2);
      p_reset = 1'b1;
      cyc(2);
      chk("rst_hold_miso", {24'd0, s_miso}, 32'hFF);
      chk("rst_hold_commit", {31'd0, wr_commit}, 32'd0);
      chk("rst_hold_err", {31'd0, frame_err}, 32'd0);
      s_css = 1'b1;
      s_clk = 1'b0;
      cyc(4);
      chk("rst_hold_miso2", {24'd0, s_miso}, 32'hFF);
      p_reset = 1'b0;
      model_clear();
      cyc(6);
      win = 1;
      set_fb(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(8, 0);
      chk("rst_rd_lit", {got[4], got[5], got[6], got[7]}, 32'h0);

      win = 0;
      cyc(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
